// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_unit : ID-stage decode plus RAW hazard stall / flush / forwarding
//                  select generation for the 5-stage pipeline.
// Optional feature macro: PIPE_FWD_EN (EX-stage operand forwarding).
// Revision: 1.0
// ============================================================================
module pipe_ctrl_unit #(
    parameter int RA_W   = 5,
    parameter int ALUC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic              ex_br_taken,
    output logic              cu_branch,
    output logic              cu_wreg,
    output logic              cu_m2reg,
    output logic              cu_wmem,
    output logic              cu_shift,
    output logic              cu_aluimm,
    output logic              cu_sext,
    output logic              cu_regrt,
    output logic [ALUC_W-1:0] cu_aluc,
    output logic              stall,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_NOR = 6'h27;
    localparam logic [5:0] FUNC_SLT = 6'h2A;
    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_SRL = 6'h02;
    localparam logic [5:0] FUNC_SRA = 6'h03;

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] ALU_NOR = ALUC_W'(4);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(5);
    localparam logic [ALUC_W-1:0] ALU_SLL = ALUC_W'(6);
    localparam logic [ALUC_W-1:0] ALU_SRL = ALUC_W'(7);
    localparam logic [ALUC_W-1:0] ALU_SRA = ALUC_W'(8);

    logic [5:0]      w_op, w_func;
    logic [RA_W-1:0] w_rs, w_rt, w_rd, w_dest;
    logic            w_branch, w_wreg, w_m2reg, w_wmem, w_shift;
    logic            w_aluimm, w_sext, w_regrt, w_func_ok;
    logic            w_use_rs, w_use_rt;
    logic [ALUC_W-1:0] w_aluc;
    logic            w_unused_shamt;

    assign w_op   = id_instr[31:26];
    assign w_func = id_instr[5:0];
    assign w_rs   = id_instr[21 +: RA_W];
    assign w_rt   = id_instr[16 +: RA_W];
    assign w_rd   = id_instr[11 +: RA_W];
    assign w_unused_shamt = ^id_instr[10:6];

    always_comb begin
        w_branch  = 1'b0;
        w_wreg    = 1'b0;
        w_m2reg   = 1'b0;
        w_wmem    = 1'b0;
        w_shift   = 1'b0;
        w_aluimm  = 1'b0;
        w_sext    = 1'b0;
        w_regrt   = 1'b0;
        w_aluc    = ALU_ADD;
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_dest    = '0;
        w_func_ok = 1'b1;
        case (w_op)
            OP_RTYPE: begin
                case (w_func)
                    FUNC_ADD: w_aluc = ALU_ADD;
                    FUNC_SUB: w_aluc = ALU_SUB;
                    FUNC_AND: w_aluc = ALU_AND;
                    FUNC_OR:  w_aluc = ALU_OR;
                    FUNC_NOR: w_aluc = ALU_NOR;
                    FUNC_SLT: w_aluc = ALU_SLT;
                    FUNC_SLL: w_aluc = ALU_SLL;
                    FUNC_SRL: w_aluc = ALU_SRL;
                    FUNC_SRA: w_aluc = ALU_SRA;
                    default:  w_func_ok = 1'b0;
                endcase
                if (w_func_ok) begin
                    w_wreg   = 1'b1;
                    w_shift  = (w_func[5:2] == 4'b0000);
                    // Shifts take their operand from rt; the rs field is don't-care.
                    w_use_rs = !w_shift;
                    w_use_rt = 1'b1;
                    w_dest   = w_rd;
                end
            end
            OP_ADDI: begin
                {w_wreg, w_sext, w_aluimm, w_regrt, w_use_rs} = 5'b11111;
                w_dest = w_rt;
            end
            OP_ANDI: begin
                {w_wreg, w_aluimm, w_regrt, w_use_rs} = 4'b1111;
                w_aluc = ALU_AND;
                w_dest = w_rt;
            end
            OP_ORI: begin
                {w_wreg, w_aluimm, w_regrt, w_use_rs} = 4'b1111;
                w_aluc = ALU_OR;
                w_dest = w_rt;
            end
            OP_LW: begin
                {w_wreg, w_m2reg, w_sext, w_aluimm, w_regrt, w_use_rs} = 6'b111111;
                w_dest = w_rt;
            end
            OP_SW: begin
                {w_wmem, w_sext, w_aluimm, w_regrt, w_use_rs, w_use_rt} = 6'b111111;
            end
            OP_BEQ: begin
                {w_branch, w_sext, w_regrt, w_use_rs, w_use_rt} = 5'b11111;
                w_aluc = ALU_SUB;
            end
            default: w_func_ok = 1'b0;
        endcase
    end

    // Only EX and MEM producers are tracked: a WB-stage producer is already
    // visible through the write-before-read register file.
    logic            ex_valid_q, ex_wreg_q;
    logic [RA_W-1:0] ex_dest_q;
    logic            mem_valid_q, mem_wreg_q;
    logic [RA_W-1:0] mem_dest_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    function automatic logic f_hit(input logic v, input logic w,
                                   input logic [RA_W-1:0] d,
                                   input logic [RA_W-1:0] src,
                                   input logic used);
        return used && v && w && (d == src) && (d != '0);
    endfunction

    logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_hazard, w_adv;

    assign w_ex_a  = f_hit(ex_valid_q,  ex_wreg_q,  ex_dest_q,  w_rs, w_use_rs);
    assign w_ex_b  = f_hit(ex_valid_q,  ex_wreg_q,  ex_dest_q,  w_rt, w_use_rt);
    assign w_mem_a = f_hit(mem_valid_q, mem_wreg_q, mem_dest_q, w_rs, w_use_rs);
    assign w_mem_b = f_hit(mem_valid_q, mem_wreg_q, mem_dest_q, w_rt, w_use_rt);

`ifdef PIPE_FWD_EN
    logic       ex_m2reg_q;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

    assign w_hazard = (w_ex_a || w_ex_b) && ex_m2reg_q;
    assign fwd_a_d  = !w_adv ? 2'b00 : w_ex_a ? 2'b01 : w_mem_a ? 2'b10 : 2'b00;
    assign fwd_b_d  = !w_adv ? 2'b00 : w_ex_b ? 2'b01 : w_mem_b ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_m2reg_q <= 1'b0;
            fwd_a_q    <= 2'b00;
            fwd_b_q    <= 2'b00;
        end else begin
            ex_m2reg_q <= w_m2reg;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    assign ex_fwd_a = fwd_a_q;
    assign ex_fwd_b = fwd_b_q;
`else
    assign w_hazard = w_ex_a || w_ex_b || w_mem_a || w_mem_b;
    assign ex_fwd_a = 2'b00;
    assign ex_fwd_b = 2'b00;
`endif

    // A taken branch flushes ID, so it overrides any hazard on that instruction.
    assign stall = id_valid && !ex_br_taken && w_hazard;
    assign w_adv = id_valid && !ex_br_taken && !w_hazard;

    assign cu_branch = w_adv & w_branch;
    assign cu_wreg   = w_adv & w_wreg;
    assign cu_m2reg  = w_adv & w_m2reg;
    assign cu_wmem   = w_adv & w_wmem;
    assign cu_shift  = w_adv & w_shift;
    assign cu_aluimm = w_adv & w_aluimm;
    assign cu_sext   = w_adv & w_sext;
    assign cu_regrt  = w_adv & w_regrt;
    assign cu_aluc   = w_adv ? w_aluc : '0;

    assign stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_wreg_q   <= 1'b0;
            ex_dest_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_wreg_q  <= 1'b0;
            mem_dest_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            mem_valid_q <= ex_valid_q;
            mem_wreg_q  <= ex_wreg_q;
            mem_dest_q  <= ex_dest_q;
            ex_valid_q  <= w_adv;
            ex_wreg_q   <= w_wreg;
            ex_dest_q   <= w_dest;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_pipe_ctrl_unit : directed and randomized checks of pipe_ctrl_unit against
//                     an instruction-level pipeline occupancy model.
// Revision: 1.0
// ============================================================================
module tb_pipe_ctrl_unit;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   id_instr;
    logic          id_valid;
    logic          ex_br_taken;
    logic          cu_branch, cu_wreg, cu_m2reg, cu_wmem, cu_shift;
    logic          cu_aluimm, cu_sext, cu_regrt;
    logic [3:0]    cu_aluc;
    logic          stall;
    logic [1:0]    ex_fwd_a, ex_fwd_b;
    logic [CW-1:0] stall_cnt;
    logic [11:0]   obs_cu;

    pipe_ctrl_unit #(.RA_W(5), .ALUC_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .ex_br_taken(ex_br_taken),
        .cu_branch(cu_branch), .cu_wreg(cu_wreg), .cu_m2reg(cu_m2reg),
        .cu_wmem(cu_wmem), .cu_shift(cu_shift), .cu_aluimm(cu_aluimm),
        .cu_sext(cu_sext), .cu_regrt(cu_regrt), .cu_aluc(cu_aluc),
        .stall(stall), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign obs_cu = {cu_branch, cu_wreg, cu_m2reg, cu_wmem, cu_shift,
                     cu_aluimm, cu_sext, cu_regrt, cu_aluc};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { bit v; bit w; bit ld; int d; } rec_t;
    typedef struct { bit wr; bit ld; bit ur; bit ut; int rs; int rt; int dest; logic [11:0] ctrl; } info_t;

    rec_t        m_ex, m_mem;
    logic [1:0]  m_fa, m_fb;
    int          m_cnt;
    info_t       e_info;
    bit          e_stall;
    logic [11:0] e_cu;
    int          total_stalls;

    function automatic logic [31:0] rins(input int fn, input int rs, input int rt, input int rd, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] iins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Per-instruction semantics: {branch,wreg,m2reg,wmem,shift,aluimm,sext,regrt,aluc}
    function automatic info_t dec(input logic [31:0] ins);
        info_t r;
        int    a;
        r = '{default: 0};
        r.rs = int'(ins[25:21]);
        r.rt = int'(ins[20:16]);
        a = -1;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20: a = 0;  6'h22: a = 1;  6'h24: a = 2;
                    6'h25: a = 3;  6'h27: a = 4;  6'h2A: a = 5;
                    6'h00: a = 6;  6'h02: a = 7;  6'h03: a = 8;
                    default: a = -1;
                endcase
                if (a >= 0) begin
                    r.wr = 1; r.ut = 1; r.ur = (a < 6); r.dest = int'(ins[15:11]);
                    r.ctrl = ((a >= 6) ? 12'h480 : 12'h400) | 12'(a);
                end
            end
            6'h08: begin r.wr = 1; r.ur = 1; r.dest = r.rt; r.ctrl = 12'h470; end
            6'h0C: begin r.wr = 1; r.ur = 1; r.dest = r.rt; r.ctrl = 12'h452; end
            6'h0D: begin r.wr = 1; r.ur = 1; r.dest = r.rt; r.ctrl = 12'h453; end
            6'h23: begin r.wr = 1; r.ld = 1; r.ur = 1; r.dest = r.rt; r.ctrl = 12'h670; end
            6'h2B: begin r.ur = 1; r.ut = 1; r.ctrl = 12'h170; end
            6'h04: begin r.ur = 1; r.ut = 1; r.ctrl = 12'h831; end
            default: r.ctrl = 12'h000;
        endcase
        return r;
    endfunction

    function automatic bit mhit(input rec_t r, input int src, input bit used);
        return used && r.v && r.w && (r.d == src) && (src != 0);
    endfunction

    function automatic logic [1:0] msel(input int src, input bit used);
        if (mhit(m_ex, src, used))  return 2'b01;
        if (mhit(m_mem, src, used)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] rand_instr();
        int k, a, b, c;
        k = $urandom_range(0, 15);
        a = $urandom_range(0, 3);
        b = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        case (k)
            0: return rins(6'h20, a, b, c, 0);
            1: return rins(6'h22, a, b, c, 0);
            2: return rins(6'h24, a, b, c, 0);
            3: return rins(6'h25, a, b, c, 0);
            4: return rins(6'h27, a, b, c, 0);
            5: return rins(6'h2A, a, b, c, 0);
            6: return rins(6'h00, a, b, c, $urandom_range(0, 31));
            7: return rins(6'h02, a, b, c, $urandom_range(0, 31));
            8: return rins(6'h03, a, b, c, $urandom_range(0, 31));
            9: return iins(6'h08, a, b, $urandom_range(0, 65535));
            10: return iins(6'h0C, a, b, $urandom_range(0, 65535));
            11: return iins(6'h0D, a, b, $urandom_range(0, 65535));
            12: return iins(6'h23, a, b, $urandom_range(0, 65535));
            13: return iins(6'h2B, a, b, $urandom_range(0, 65535));
            14: return iins(6'h04, a, b, $urandom_range(0, 65535));
            default: return ($urandom_range(0, 1) == 0) ? iins(6'h3F, a, b, 0) : rins(6'h01, a, b, c, 0);
        endcase
    endfunction

    // Apply ID inputs, move to the sampling point and form expectations.
    task automatic drive(input logic [31:0] ins, input logic v, input logic br);
        bit h;
        id_instr    = ins;
        id_valid    = v;
        ex_br_taken = br;
        @(negedge clk);
        e_info = dec(ins);
        h = (mhit(m_ex, e_info.rs, e_info.ur) || mhit(m_ex, e_info.rt, e_info.ut));
`ifdef PIPE_FWD_EN
        h = h && m_ex.ld;
`else
        h = h || mhit(m_mem, e_info.rs, e_info.ur) || mhit(m_mem, e_info.rt, e_info.ut);
`endif
        e_stall = v && !br && h;
        e_cu    = (v && !br && !e_stall) ? e_info.ctrl : 12'h000;
    endtask

    task automatic tick();
        bit adv;
        @(posedge clk);
        if (rst) begin
            m_ex  = '{default: 0};
            m_mem = '{default: 0};
            m_fa  = 2'b00;
            m_fb  = 2'b00;
            m_cnt = 0;
        end else begin
            adv = id_valid && !ex_br_taken && !e_stall;
            if (e_stall) total_stalls++;
            if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
`ifdef PIPE_FWD_EN
            m_fa = adv ? msel(e_info.rs, e_info.ur) : 2'b00;
            m_fb = adv ? msel(e_info.rt, e_info.ut) : 2'b00;
`else
            m_fa = 2'b00;
            m_fb = 2'b00;
`endif
            m_mem = m_ex;
            m_ex  = '{v: adv, w: e_info.wr, ld: e_info.ld, d: e_info.dest};
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(32'h0, 1'b0, 1'b0);
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_tests++;
        if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd got=%b%b exp=0000", ex_fwd_a, ex_fwd_b); end
        n_tests++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(rins(6'h20, 1, 2, 3, 0), 1'b1, 1'b0);
        tick();
`ifdef PIPE_FWD_EN
        drive(rins(6'h22, 3, 5, 4, 0), 1'b1, 1'b0);
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%b exp=0", stall); end
        tick();
        drive(32'h0, 1'b0, 1'b0);
        n_tests++;
        if (ex_fwd_a !== 2'b01 || ex_fwd_b !== 2'b00) begin
            n_fail++; $display("FAIL b2b_fwd got=%b/%b exp=01/00", ex_fwd_a, ex_fwd_b);
        end
`else
        for (int i = 0; i < 3; i++) begin
            drive(rins(6'h25, 3, 3, 4, 0), 1'b1, 1'b0);
            n_tests++;
            if (stall !== (i < 2)) begin n_fail++; $display("FAIL b2b_nofwd_stall c%0d got=%b exp=%b", i, stall, i < 2); end
            tick();
        end
        drive(32'h0, 1'b0, 1'b0);
        n_tests++;
        if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL b2b_nofwd_fwd got=%b%b exp=0000", ex_fwd_a, ex_fwd_b); end
`endif
        tick();
    endtask

    task automatic test_load_use();
        int ns;
`ifdef PIPE_FWD_EN
        ns = 1;
`else
        ns = 2;
`endif
        do_reset();
        drive(iins(6'h23, 1, 2, 0), 1'b1, 1'b0);
        tick();
        for (int i = 0; i <= ns; i++) begin
            drive(rins(6'h20, 2, 2, 3, 0), 1'b1, 1'b0);
            n_tests++;
            if (stall !== (i < ns)) begin n_fail++; $display("FAIL lu_stall c%0d got=%b exp=%b", i, stall, i < ns); end
            n_tests++;
            if (obs_cu !== ((i < ns) ? 12'h000 : 12'h400)) begin
                n_fail++; $display("FAIL lu_cu c%0d got=%h exp=%h", i, obs_cu, (i < ns) ? 12'h000 : 12'h400);
            end
            tick();
        end
        drive(32'h0, 1'b0, 1'b0);
        n_tests++;
`ifdef PIPE_FWD_EN
        if (ex_fwd_a !== 2'b10 || ex_fwd_b !== 2'b10) begin n_fail++; $display("FAIL lu_fwd got=%b/%b exp=10/10", ex_fwd_a, ex_fwd_b); end
`else
        if (ex_fwd_a !== 2'b00 || ex_fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd got=%b/%b exp=00/00", ex_fwd_a, ex_fwd_b); end
`endif
        n_tests++;
        if (stall_cnt !== CW'(ns)) begin n_fail++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, ns); end
        tick();
    endtask

    task automatic test_zero_dest();
        do_reset();
        drive(iins(6'h08, 1, 0, 5), 1'b1, 1'b0);
        tick();
        drive(rins(6'h20, 0, 0, 6, 0), 1'b1, 1'b0);
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall got=%b exp=0", stall); end
        tick();
        drive(iins(6'h23, 1, 9, 0), 1'b1, 1'b0);
        n_tests++;
        if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL zero_fwd got=%b%b exp=0000", ex_fwd_a, ex_fwd_b); end
        tick();
        drive(rins(6'h00, 9, 2, 7, 3), 1'b1, 1'b0);
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL sll_rs_stall got=%b exp=0", stall); end
        n_tests++;
        if (obs_cu !== 12'h486) begin n_fail++; $display("FAIL sll_cu got=%h exp=486", obs_cu); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(iins(6'h23, 1, 2, 0), 1'b1, 1'b0);
        tick();
        drive(rins(6'h20, 2, 2, 3, 0), 1'b1, 1'b1);
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", stall); end
        n_tests++;
        if (obs_cu !== 12'h000) begin n_fail++; $display("FAIL flush_cu got=%h exp=000", obs_cu); end
        tick();
        drive(rins(6'h25, 3, 3, 5, 0), 1'b1, 1'b0);
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_bubble_stall got=%b exp=0", stall); end
        n_tests++;
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=0", stall_cnt); end
        tick();
        drive(32'h0, 1'b0, 1'b0);
        n_tests++;
        if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL flush_fwd got=%b%b exp=0000", ex_fwd_a, ex_fwd_b); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(iins(6'h23, 1, 2, 0), 1'b1, 1'b0);
        tick();
        drive(rins(6'h20, 2, 2, 3, 0), 1'b1, 1'b0);
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(rins(6'h20, 2, 2, 3, 0), 1'b1, 1'b0);
        n_tests++;
        if (stall !== 1'b0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL mid_rst got stall=%b cnt=%0d exp stall=0 cnt=0", stall, stall_cnt);
        end
        n_tests++;
        if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_fwd got=%b%b exp=0000", ex_fwd_a, ex_fwd_b); end
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0));
            n_tests++;
            if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, stall, e_stall); end
            n_tests++;
            if (obs_cu !== e_cu) begin n_fail++; $display("FAIL rnd_cu i=%0d ins=%h got=%h exp=%h", i, id_instr, obs_cu, e_cu); end
            n_tests++;
            if (ex_fwd_a !== m_fa || ex_fwd_b !== m_fb) begin
                n_fail++; $display("FAIL rnd_fwd i=%0d got=%b/%b exp=%b/%b", i, ex_fwd_a, ex_fwd_b, m_fa, m_fb);
            end
            n_tests++;
            if (stall_cnt !== CW'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, stall_cnt, m_cnt); end
            tick();
        end
    endtask

    task automatic test_saturation();
        int iter;
        do_reset();
        total_stalls = 0;
        iter = 0;
        while (total_stalls < (1 << CW) + 3 && iter < 2000) begin
            drive(iins(6'h23, 1, 2, 0), 1'b1, 1'b0);
            tick();
            for (int k = 0; k < 3; k++) begin
                drive(rins(6'h20, 2, 2, 3, 0), 1'b1, 1'b0);
                tick();
            end
            iter++;
        end
        drive(32'h0, 1'b0, 1'b0);
        n_tests++;
        if (total_stalls < (1 << CW) + 3) begin n_fail++; $display("FAIL sat_budget got=%0d exp>=%0d", total_stalls, (1 << CW) + 3); end
        n_tests++;
        if (stall_cnt !== {CW{1'b1}}) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=%0d", stall_cnt, (1 << CW) - 1); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        id_instr = 32'h0;
        id_valid = 1'b0;
        ex_br_taken = 1'b0;
        m_ex = '{default: 0};
        m_mem = '{default: 0};
        m_fa = 2'b00;
        m_fb = 2'b00;
        m_cnt = 0;
        total_stalls = 0;
        e_stall = 1'b0;
        e_info = '{default: 0};
        e_cu = 12'h000;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_zero_dest();
        test_flush();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
